// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags and reorder-slot state.
// Imported by fpnew_result_reorder.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    ROB_FREE    = 2'd0,
    ROB_PENDING = 2'd1,
    ROB_DONE    = 2'd2
  } rob_state_e;

endpackage

// File: rtl/fpnew_result_reorder.sv
// In-order retirement of out-of-order FPU results, restoring user tags.
// Optional FPNEW_ROB_BYPASS_EN: same-cycle result-to-retire path.
module fpnew_result_reorder
  import fpnew_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter type TagType = logic,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  TagType           req_tag_i,
  output logic             unit_valid_o,
  input  logic             unit_ready_i,
  output logic [IdxW-1:0]  unit_tag_o,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [IdxW-1:0]  res_tag_i,
  input  logic [Width-1:0] res_result_i,
  input  status_t          res_status_i,
  input  logic             res_ext_bit_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_result_o,
  output status_t          out_status_o,
  output logic             out_ext_bit_o,
  output TagType           out_tag_o,
  output logic             busy_o
);

  typedef logic [IdxW:0] ptr_t;

  typedef struct packed {
    rob_state_e       state;
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } rob_entry_t;

  rob_entry_t      rob_q [Depth];
  rob_entry_t      head;
  ptr_t            wr_ptr_q;
  ptr_t            rd_ptr_q;
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] rd_idx;
  logic            full;
  logic            kill;
  logic            alloc;
  logic            res_hit;
  logic            bad_res;
  logic            retire;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];
  assign full   = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW])
               && (wr_idx == rd_idx);

  // Reset mid-operation behaves like a flush.
  assign kill = flush_i | rst_i;

  assign req_ready_o  = unit_ready_i & ~full;
  assign unit_valid_o = req_valid_i & ~full & ~kill;
  assign unit_tag_o   = wr_idx;
  assign alloc        = unit_valid_o & unit_ready_i;
  assign res_ready_o  = 1'b1;

  assign head    = rob_q[rd_idx];
  assign res_hit = res_valid_i & ~kill
                 & (rob_q[res_tag_i].state == ROB_PENDING);
  assign bad_res = res_valid_i & ~kill
                 & (rob_q[res_tag_i].state != ROB_PENDING);

`ifdef FPNEW_ROB_BYPASS_EN
  logic bypass;

  assign bypass        = res_hit & (res_tag_i == rd_idx);
  assign out_valid_o   = (head.state == ROB_DONE) | bypass;
  assign out_result_o  = bypass ? res_result_i  : head.result;
  assign out_status_o  = bypass ? res_status_i  : head.status;
  assign out_ext_bit_o = bypass ? res_ext_bit_i : head.ext_bit;
`else
  assign out_valid_o   = (head.state == ROB_DONE);
  assign out_result_o  = head.result;
  assign out_status_o  = head.status;
  assign out_ext_bit_o = head.ext_bit;
`endif

  assign out_tag_o = head.tag;
  assign retire    = out_valid_o & out_ready_i;

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (rob_q[i].state != ROB_FREE) busy_o = 1'b1;
    end
  end

  // Retire is applied last so a bypassed result frees its slot directly.
  always_ff @(posedge clk_i) begin
    if (kill) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        rob_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        rob_q[wr_idx].state <= ROB_PENDING;
        rob_q[wr_idx].tag   <= req_tag_i;
        wr_ptr_q            <= wr_ptr_q + ptr_t'(1);
      end
      if (res_hit) begin
        rob_q[res_tag_i].state   <= ROB_DONE;
        rob_q[res_tag_i].result  <= res_result_i;
        rob_q[res_tag_i].status  <= res_status_i;
        rob_q[res_tag_i].ext_bit <= res_ext_bit_i;
      end
      if (retire) begin
        rob_q[rd_idx].state <= ROB_FREE;
        rd_ptr_q            <= rd_ptr_q + ptr_t'(1);
      end
    end
  end

  bad_res_a: assert property (@(posedge clk_i) !bad_res);

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Randomized + directed bench for fpnew_result_reorder.
// Honors FPNEW_ROB_BYPASS_EN when defined.
module tb_fpnew_result_reorder;
  import fpnew_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam int IW = 2;
`ifdef FPNEW_ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [7:0] tag_t;

  logic          clk;
  logic          rst_i, flush_i;
  logic          req_valid_i, req_ready_o;
  tag_t          req_tag_i;
  logic          unit_valid_o, unit_ready_i;
  logic [IW-1:0] unit_tag_o;
  logic          res_valid_i, res_ready_o;
  logic [IW-1:0] res_tag_i;
  logic [W-1:0]  res_result_i;
  status_t       res_status_i;
  logic          res_ext_bit_i;
  logic          out_valid_o, out_ready_i;
  logic [W-1:0]  out_result_o;
  status_t       out_status_o;
  logic          out_ext_bit_o;
  tag_t          out_tag_o;
  logic          busy_o;

  fpnew_result_reorder #(
    .Width(W), .Depth(D), .TagType(tag_t)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tag_i(req_tag_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_tag_o(unit_tag_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_tag_i(res_tag_i), .res_result_i(res_result_i),
    .res_status_i(res_status_i), .res_ext_bit_i(res_ext_bit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_status_o(out_status_o),
    .out_ext_bit_o(out_ext_bit_o), .out_tag_o(out_tag_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    tag_t         tag;
    bit           done;
    logic [W-1:0] res;
    status_t      st;
    logic         ext;
  } op_t;

  op_t q[$];
  int  n_iss, n_ret;
  int  total, passed;

  logic         obs_ov, obs_rr, obs_uv, obs_busy;
  logic [IW-1:0] obs_ut;
  tag_t         obs_tag;
  logic [W-1:0] obs_res;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else passed++;
  endtask

  task automatic clr();
    rst_i = 0; flush_i = 0; req_valid_i = 0; unit_ready_i = 0;
    req_tag_i = '0; res_valid_i = 0; res_tag_i = '0;
    res_result_i = '0; res_status_i = '0; res_ext_bit_i = 0;
    out_ready_i = 0;
  endtask

  // One cycle: compare DUT to the model, then advance the model.
  task automatic step();
    bit full, e_ov, byp;
    int k;
    op_t hd;
    @(negedge clk);
    full = (q.size() == D);
    k = (int'(res_tag_i) - (n_ret % D) + D) % D;
    byp = 0;
    if (BYP)
      byp = res_valid_i && !flush_i && !rst_i && q.size() > 0
            && k == 0 && !q[0].done;
    e_ov = (q.size() > 0 && q[0].done) || byp;
    obs_ov = out_valid_o; obs_rr = req_ready_o; obs_uv = unit_valid_o;
    obs_busy = busy_o; obs_ut = unit_tag_o; obs_tag = out_tag_o;
    obs_res = out_result_o;
    if (!rst_i) begin
      chk("req_ready", 64'(req_ready_o), 64'(unit_ready_i && !full));
      chk("unit_valid", 64'(unit_valid_o),
          64'(req_valid_i && !full && !flush_i));
      chk("unit_tag", 64'(unit_tag_o), 64'(n_iss % D));
      chk("res_ready", 64'(res_ready_o), 64'd1);
      chk("busy", 64'(busy_o), 64'(q.size() > 0));
      chk("out_valid", 64'(out_valid_o), 64'(e_ov));
      if (e_ov) begin
        hd = q[0];
        if (byp) begin
          hd.res = res_result_i; hd.st = res_status_i;
          hd.ext = res_ext_bit_i;
        end
        chk("out_result", 64'(out_result_o), 64'(hd.res));
        chk("out_status", 64'(out_status_o), 64'(hd.st));
        chk("out_ext", 64'(out_ext_bit_o), 64'(hd.ext));
        chk("out_tag", 64'(out_tag_o), 64'(hd.tag));
      end
    end
    if (rst_i || flush_i) begin
      q.delete(); n_iss = 0; n_ret = 0;
    end else begin
      if (res_valid_i && k < q.size() && !q[k].done) begin
        q[k].done = 1; q[k].res = res_result_i;
        q[k].st = res_status_i; q[k].ext = res_ext_bit_i;
      end
      if (e_ov && out_ready_i) begin
        void'(q.pop_front()); n_ret++;
      end
      if (req_valid_i && unit_ready_i && !full) begin
        q.push_back('{tag: req_tag_i, done: 0, res: '0,
                      st: '0, ext: 0});
        n_iss++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(tag_t t);
    clr(); req_valid_i = 1; unit_ready_i = 1; req_tag_i = t; step();
  endtask

  task automatic ret(int idx, logic orr, logic [W-1:0] v);
    clr(); res_valid_i = 1; res_tag_i = IW'(idx);
    res_result_i = v; res_status_i = status_t'(v[4:0]);
    res_ext_bit_i = v[5]; out_ready_i = orr; step();
  endtask

  initial begin
    int pend[$];
    total = 0; passed = 0; n_iss = 0; n_ret = 0;
    clr(); rst_i = 1;
    @(posedge clk); #1;

    // reset with req_valid held high
    clr(); rst_i = 1; req_valid_i = 1; unit_ready_i = 1; step(); step();
    clr(); step();
    chk("rst_ov", 64'(obs_ov), 64'd0);
    chk("rst_busy", 64'(obs_busy), 64'd0);
    chk("rst_utag", 64'(obs_ut), 64'd0);

    // in-order
    issue(8'hA1); chk("io_ut0", 64'(obs_ut), 64'd0);
    issue(8'hB2); chk("io_ut1", 64'(obs_ut), 64'd1);
    ret(0, 1, 32'h1111_0001);
    chk("io_r0_ov", 64'(obs_ov), 64'(BYP));
    if (BYP) chk("io_r0_tag", 64'(obs_tag), 64'hA1);
    ret(1, 1, 32'h2222_0002);
    chk("io_r1_ov", 64'(obs_ov), 64'd1);
    chk("io_r1_tag", 64'(obs_tag), BYP ? 64'hB2 : 64'hA1);
    clr(); out_ready_i = 1; step();
    chk("io_r2_ov", 64'(obs_ov), 64'(!BYP));
    if (!BYP) chk("io_r2_tag", 64'(obs_tag), 64'hB2);

    // out-of-order and full
    clr(); rst_i = 1; step();
    for (int i = 0; i < D; i++) begin
      issue(tag_t'(8'h10 + i));
      chk("ooo_ut", 64'(obs_ut), 64'(i));
    end
    issue(8'h20);
    chk("full_rr", 64'(obs_rr), 64'd0);
    chk("full_uv", 64'(obs_uv), 64'd0);
    ret(3, 1, 32'h3333_0003); chk("ooo_3", 64'(obs_ov), 64'd0);
    ret(1, 1, 32'h3333_0001); chk("ooo_1", 64'(obs_ov), 64'd0);
    ret(2, 1, 32'h3333_0002); chk("ooo_2", 64'(obs_ov), 64'd0);
    ret(0, 0, 32'h3333_0000); chk("ooo_0", 64'(obs_ov), 64'(BYP));
    clr(); req_valid_i = 1; unit_ready_i = 1; req_tag_i = 8'h20;
    out_ready_i = 1; step();
    chk("wrap_t_tag", 64'(obs_tag), 64'h10);
    chk("wrap_t_rr", 64'(obs_rr), 64'd0);
    step();
    chk("wrap_t1_rr", 64'(obs_rr), 64'd1);
    chk("wrap_t1_ut", 64'(obs_ut), 64'd0);
    chk("ooo_tag11", 64'(obs_tag), 64'h11);
    clr(); out_ready_i = 1; step();
    chk("ooo_tag12", 64'(obs_tag), 64'h12);
    step(); chk("ooo_tag13", 64'(obs_tag), 64'h13);
    step(); chk("ooo_end_ov", 64'(obs_ov), 64'd0);

    // backpressure on head holding tag 20
    issue(8'h21); issue(8'h22);
    ret(0, 0, 32'hBEEF_0020);
    for (int i = 0; i < 3; i++) begin
      clr(); step();
      chk("bp_ov", 64'(obs_ov), 64'd1);
      chk("bp_tag", 64'(obs_tag), 64'h20);
      chk("bp_res", 64'(obs_res), 64'hBEEF_0020);
    end
    clr(); out_ready_i = 1; step();
    chk("bp_ret", 64'(obs_tag), 64'h20);
    clr(); step(); chk("bp_after", 64'(obs_ov), 64'd0);
    issue(8'h23);

    // flush with a same-cycle result and request
    clr(); flush_i = 1; res_valid_i = 1; res_tag_i = 2'd1;
    req_valid_i = 1; unit_ready_i = 1; step();
    clr(); step();
    chk("fl_busy", 64'(obs_busy), 64'd0);
    chk("fl_ov", 64'(obs_ov), 64'd0);
    issue(8'h30); chk("fl_ut", 64'(obs_ut), 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clr();
      rst_i = ($urandom_range(0, 299) == 0);
      flush_i = ($urandom_range(0, 63) == 0);
      req_valid_i = $urandom_range(0, 1);
      unit_ready_i = ($urandom_range(0, 3) != 0);
      req_tag_i = tag_t'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(0, 1)) begin
        res_valid_i = 1;
        res_tag_i = IW'((n_ret +
          pend[$urandom_range(0, pend.size() - 1)]) % D);
        res_result_i = $urandom;
        res_status_i = status_t'($urandom_range(0, 31));
        res_ext_bit_i = $urandom_range(0, 1);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
